// File: rtl/ps2_scan_rx_pkg.sv
// PS/2 receiver shared definitions: frame FSM states and prefix bytes.
// is_event() tells an ordinary scancode (E1 included) from a prefix.
package ps2_scan_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // E1 (Pause) is passed through as a plain code
  function automatic logic is_event(input logic [7:0] b);
    return (b == PS2_PAUSE) ||
           ((b != PS2_BRK) && (b != PS2_EXT));
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 pin conditioner: 2-FF synchroniser plus stability filter.
// Ports: clock, reset (sync, high), pin (async in), level (filtered, resets to 1).
module ps2_filter #(
  parameter int unsigned FILTER = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level
);

  localparam int CW = $clog2(FILTER + 1);

  logic          s0;
  logic          s1;
  logic [CW-1:0] cnt;

  // level follows s1 only after FILTER differing samples in a row
  always_ff @(posedge clock) begin
    if (reset) begin
      s0    <= 1'b1;
      s1    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      s0 <= pin;
      s1 <= s0;
      if (s1 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER - 1)) begin
        level <= s1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: frames, E0/F0 prefixes -> kstb/make/code/ext.
// Ports: clock, reset, ps2Ck, ps2D in; kstb, make, code, ext, err out.
// Define PS2_WATCHDOG_EN to abort partial frames after TIMEOUT cycles.
module ps2_scan_rx
  import ps2_scan_rx_pkg::*;
#(
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 56000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2D,
  output logic       kstb,
  output logic       make,
  output logic [7:0] code,
  output logic       ext,
  output logic       err
);

  logic       ck_f;
  logic       d_f;
  logic       ck_q;
  logic       fall;
  state_t     state;
  logic [7:0] sr;
  logic [2:0] bcnt;
  logic       par;
  logic       pok;
  logic       brk;
  logic       extf;

  ps2_filter #(.FILTER(FILTER)) u_ck (
    .clock(clock),
    .reset(reset),
    .pin  (ps2Ck),
    .level(ck_f)
  );

  ps2_filter #(.FILTER(FILTER)) u_d (
    .clock(clock),
    .reset(reset),
    .pin  (ps2D),
    .level(d_f)
  );

  assign fall = ck_q & ~ck_f;

`ifdef PS2_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT);
  logic [WW-1:0] wd;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT != 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      ck_q  <= 1'b1;
      state <= IDLE;
      sr    <= '0;
      bcnt  <= '0;
      par   <= 1'b1;
      pok   <= 1'b0;
      brk   <= 1'b0;
      extf  <= 1'b0;
      kstb  <= 1'b0;
      make  <= 1'b0;
      code  <= '0;
      ext   <= 1'b0;
      err   <= 1'b0;
`ifdef PS2_WATCHDOG_EN
      wd    <= '0;
`endif
    end else begin
      ck_q <= ck_f;
      kstb <= 1'b0;
      err  <= 1'b0;
      if (fall) begin
        unique case (state)
          IDLE: begin
            if (!d_f) begin
              state <= DATA;
              bcnt  <= '0;
              par   <= 1'b1;
            end
          end
          DATA: begin
            sr   <= {d_f, sr[7:1]};
            par  <= par ^ d_f;
            bcnt <= bcnt + 3'd1;
            if (bcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            // par started at 1, so odd parity leaves it equal to the bit
            pok   <= (par == d_f);
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (d_f && pok) begin
              if (is_event(sr)) begin
                kstb <= 1'b1;
                code <= sr;
                make <= ~brk;
                ext  <= extf;
                brk  <= 1'b0;
                extf <= 1'b0;
              end else if (sr == PS2_BRK) begin
                brk <= 1'b1;
              end else begin
                extf <= 1'b1;
              end
            end else begin
              err  <= 1'b1;
              brk  <= 1'b0;
              extf <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
`ifdef PS2_WATCHDOG_EN
      // timeout only fires without a fall, so it never collides with kstb
      if (fall) begin
        wd <= '0;
      end else if (state != IDLE) begin
        wd <= wd + WW'(1);
        if (wd == WW'(TIMEOUT - 1)) begin
          state <= IDLE;
          err   <= 1'b1;
          brk   <= 1'b0;
          extf  <= 1'b0;
          wd    <= '0;
        end
      end
`endif
    end
  end

endmodule
